// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer: FSM state encoding,
// instruction size, default widths and reset PC, plus a small alignment helper.
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned XLEN_DEFAULT     = 32;
   localparam int unsigned INSN_BYTES       = 4;
   localparam int unsigned ALIGN_BITS       = 2;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch FSM state encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DRAIN = 3'd4
   } fetch_state_t;

   // True when the low address bits would not land on an instruction boundary
   function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] low_bits);
      return (low_bits != ALIGN_BITS'(0));
   endfunction

endpackage : fetch_pkg

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// One-entry instruction/pc holding register presented to decode with a
// valid/ready handshake. Load has priority over clear; the owner decides when
// an entry is dropped (consumed or redirected away).
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_load       capture i_data/i_pc and raise o_valid
//   i_clear      drop the held entry (o_valid <= 0)
//   i_data       instruction word to capture
//   i_pc         address of i_data
//   i_ready      decode ready
//   o_valid      entry valid to decode
//   o_data       held instruction word
//   o_pc         held instruction address
//   o_fire_c     combinational handshake (o_valid & i_ready)
// -----------------------------------------------------------------------------
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic [XLEN-1:0] i_data,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_ready,
   output logic            o_valid,
   output logic [XLEN-1:0] o_data,
   output logic [XLEN-1:0] o_pc,
   output logic            o_fire_c
);

   logic            r_valid;
   logic [XLEN-1:0] r_data;
   logic [XLEN-1:0] r_pc;

   // Holding register; data/pc stay stable until the next load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_pc    <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_pc    <= i_pc;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid  = r_valid;
   assign o_data   = r_data;
   assign o_pc     = r_pc;
   assign o_fire_c = r_valid & i_ready;

endmodule : fetch_buffer

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
// Sequences the program counter through instruction fetch: issues one fetch
// at a time to instruction memory, buffers the returned word for decode and
// applies redirects, draining any stale in-flight fetch.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts request this cycle
//   imem_req_addr     fetch address (current pc)
//   imem_rsp_valid    response word valid (one per accepted request)
//   imem_rsp_data     instruction word
//   ins_valid         buffered instruction valid to decode
//   ins_ready         decode consumes instruction
//   ins_data          instruction word
//   ins_pc            address of ins_data
//   redirect_valid    redirect request (taken branch / jal / jalr)
//   redirect_target   new pc
//   misaligned        one-cycle pulse after a redirect with target[1:0] != 0
// -----------------------------------------------------------------------------
module pc_fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
)(
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            ins_valid,
   input  logic            ins_ready,
   output logic [XLEN-1:0] ins_data,
   output logic [XLEN-1:0] ins_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            misaligned
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_req_valid;
   logic            r_misaligned;

   logic            w_accept;
   logic            w_rsp_load;
   logic            w_buf_clear;
   logic            w_fire;
   logic [XLEN-1:0] w_target_aligned;
   logic [XLEN-1:0] w_pc_seq;

   // r_req_valid is high exactly while in REQ, so accept needs no state decode
   assign w_accept         = r_req_valid & imem_req_ready;
   assign w_target_aligned = {redirect_target[XLEN-1:ALIGN_BITS], ALIGN_BITS'(0)};
   assign w_pc_seq         = r_pc + XLEN'(INSN_BYTES);

   // A response coinciding with a redirect is stale and never reaches decode
   assign w_rsp_load  = (r_state == ST_WAIT) & imem_rsp_valid & ~redirect_valid;
   // Held entry is dropped when consumed or when a redirect overrides it
   assign w_buf_clear = (r_state == ST_HOLD) & (redirect_valid | w_fire);

   // Fetch FSM, pc register and registered request/misaligned outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_req_valid  <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         r_misaligned <= 1'b0;
         if (redirect_valid && (r_state != ST_IDLE)) begin
            r_misaligned <= is_misaligned(redirect_target[ALIGN_BITS-1:0]);
         end

         case (r_state)
            // One dead cycle after reset release
            ST_IDLE: begin
               r_state     <= ST_REQ;
               r_req_valid <= 1'b1;
            end

            // Address may move with redirects until the memory accepts
            ST_REQ: begin
               if (redirect_valid) begin
                  r_pc <= w_target_aligned;
               end
               if (w_accept) begin
                  r_req_valid <= 1'b0;
                  r_state     <= redirect_valid ? ST_DRAIN : ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (redirect_valid) begin
                  r_pc <= w_target_aligned;
                  if (imem_rsp_valid) begin
                     r_state     <= ST_REQ;
                     r_req_valid <= 1'b1;
                  end else begin
                     r_state <= ST_DRAIN;
                  end
               end else if (imem_rsp_valid) begin
                  r_state <= ST_HOLD;
               end
            end

            // Redirect wins over sequential advance
            ST_HOLD: begin
               if (redirect_valid) begin
                  r_pc        <= w_target_aligned;
                  r_state     <= ST_REQ;
                  r_req_valid <= 1'b1;
               end else if (w_fire) begin
                  r_pc        <= w_pc_seq;
                  r_state     <= ST_REQ;
                  r_req_valid <= 1'b1;
               end
            end

            // Wait out the stale response; keep the latest redirect target
            ST_DRAIN: begin
               if (redirect_valid) begin
                  r_pc <= w_target_aligned;
               end
               if (imem_rsp_valid) begin
                  r_state     <= ST_REQ;
                  r_req_valid <= 1'b1;
               end
            end

            default: begin
               r_state     <= ST_IDLE;
               r_req_valid <= 1'b0;
            end
         endcase
      end
   end

   fetch_buffer #(
      .XLEN (XLEN)
   ) u_fetch_buffer (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_rsp_load),
      .i_clear  (w_buf_clear),
      .i_data   (imem_rsp_data),
      .i_pc     (r_pc),
      .i_ready  (ins_ready),
      .o_valid  (ins_valid),
      .o_data   (ins_data),
      .o_pc     (ins_pc),
      .o_fire_c (w_fire)
   );

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_pc;
   assign misaligned     = r_misaligned;

endmodule : pc_fetch_sequencer

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Directed bench for pc_fetch_sequencer. Words that should reach decode are
// pushed to a scoreboard when their response is driven; a negedge monitor
// compares every presented instruction against the head of that queue.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            reset;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            ins_valid;
   logic            ins_ready;
   logic [XLEN-1:0] ins_data;
   logic [XLEN-1:0] ins_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            misaligned;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   pc_fetch_sequencer #(
      .XLEN     (XLEN),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .ins_valid       (ins_valid),
      .ins_ready       (ins_ready),
      .ins_data        (ins_data),
      .ins_pc          (ins_pc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .misaligned      (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From REQ with ready=1 and ins_ready=1: one full REQ/WAIT/HOLD round
   task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word);
      exp_t e;
      chk("req_valid", 32'(imem_req_valid), 32'd1);
      chk("req_addr", imem_req_addr, addr);
      step();
      chk("wait_no_req", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word;
      e.pc   = addr;
      e.data = word;
      sb.push_back(e);
      step();
      imem_rsp_valid = 1'b0;
      chk("hold_valid", 32'(ins_valid), 32'd1);
      chk("hold_pc", ins_pc, addr);
      chk("hold_data", ins_data, word);
      chk("hold_no_req", 32'(imem_req_valid), 32'd0);
      step();
   endtask

   // Scoreboard monitor: any presented word must be the expected head entry
   always @(negedge clk) begin
      if (!reset && ins_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_ins_valid", 32'(ins_valid), 32'd0);
         end else begin
            chk("sb_pc", ins_pc, sb[0].pc);
            chk("sb_data", ins_data, sb[0].data);
            if (ins_ready || redirect_valid) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset           = 1'b1;
      imem_req_ready  = 1'b1;
      imem_rsp_valid  = 1'b0;
      imem_rsp_data   = '0;
      ins_ready       = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = '0;

      // Reset state
      step();
      step();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_ins_valid", 32'(ins_valid), 32'd0);
      chk("rst_ins_data", ins_data, 32'd0);
      chk("rst_ins_pc", ins_pc, 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      chk("rst_addr", imem_req_addr, 32'd0);
      reset = 1'b0;
      chk("idle_no_req", 32'(imem_req_valid), 32'd0);
      step();

      // Back-to-back fetches: 3 cycles each
      fetch_one(32'h0, 32'h0000_0013);
      fetch_one(32'h4, 32'h0000_0093);
      chk("seq_addr_8", imem_req_addr, 32'h8);

      // Decode stalls 5 cycles in HOLD
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0022;
      sb.push_back('{pc: 32'h8, data: 32'h0000_0022});
      step();
      imem_rsp_valid = 1'b0;
      ins_ready      = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(ins_valid), 32'd1);
         chk("stall_data", ins_data, 32'h0000_0022);
         chk("stall_pc", ins_pc, 32'h8);
         chk("stall_no_req", 32'(imem_req_valid), 32'd0);
         step();
      end
      ins_ready = 1'b1;
      step();
      chk("after_stall_req", 32'(imem_req_valid), 32'd1);
      chk("after_stall_addr", imem_req_addr, 32'hC);

      // Redirect in WAIT, stale response 2 cycles later
      step();
      redirect_valid  = 1'b1;
      redirect_target = 32'h100;
      step();
      redirect_valid = 1'b0;
      chk("drain_no_req", 32'(imem_req_valid), 32'd0);
      chk("drain_misaligned", 32'(misaligned), 32'd0);
      step();
      chk("drain_no_req2", 32'(imem_req_valid), 32'd0);
      chk("drain_no_ins", 32'(ins_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      step();
      imem_rsp_valid = 1'b0;
      chk("stale_dropped", 32'(ins_valid), 32'd0);
      chk("redir_req", 32'(imem_req_valid), 32'd1);
      chk("redir_addr", imem_req_addr, 32'h100);

      // Redirect in HOLD coincident with handshake
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0033;
      sb.push_back('{pc: 32'h100, data: 32'h0000_0033});
      step();
      imem_rsp_valid = 1'b0;
      chk("hold_redir_valid", 32'(ins_valid), 32'd1);
      redirect_valid  = 1'b1;
      redirect_target = 32'h40;
      step();
      redirect_valid = 1'b0;
      chk("hold_redir_drop", 32'(ins_valid), 32'd0);
      chk("hold_redir_req", 32'(imem_req_valid), 32'd1);
      chk("hold_redir_addr", imem_req_addr, 32'h40);

      // Redirect in REQ without accept, then wrap at top of address space
      imem_req_ready  = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      chk("req_redir_req", 32'(imem_req_valid), 32'd1);
      chk("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
      imem_req_ready = 1'b1;
      fetch_one(32'hFFFF_FFFC, 32'h0000_0044);
      chk("wrap_addr", imem_req_addr, 32'h0);

      // Misaligned redirect: aligned pc and a single pulse
      imem_req_ready  = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h203;
      step();
      redirect_valid = 1'b0;
      chk("mis_addr", imem_req_addr, 32'h200);
      chk("mis_pulse", 32'(misaligned), 32'd1);
      step();
      chk("mis_pulse_end", 32'(misaligned), 32'd0);
      chk("mis_addr_hold", imem_req_addr, 32'h200);
      imem_req_ready = 1'b1;
      fetch_one(32'h200, 32'h0000_0055);
      chk("post_mis_addr", imem_req_addr, 32'h204);

      // Asynchronous reset while in DRAIN
      step();
      redirect_valid  = 1'b1;
      redirect_target = 32'h300;
      step();
      redirect_valid = 1'b0;
      chk("pre_rst_drain", 32'(imem_req_valid), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("arst_addr", imem_req_addr, 32'h0);
      chk("arst_ins_valid", 32'(ins_valid), 32'd0);
      chk("arst_ins_data", ins_data, 32'd0);
      chk("arst_ins_pc", ins_pc, 32'd0);
      chk("arst_misaligned", 32'(misaligned), 32'd0);
      step();
      step();
      reset          = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0BAD;
      chk("idle2_no_req", 32'(imem_req_valid), 32'd0);
      step();
      imem_rsp_valid = 1'b0;
      chk("stray_idle_req", 32'(imem_req_valid), 32'd1);
      chk("stray_idle_addr", imem_req_addr, 32'h0);
      chk("stray_idle_ins", 32'(ins_valid), 32'd0);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      step();
      imem_rsp_valid = 1'b0;
      chk("stray_req_req", 32'(imem_req_valid), 32'd1);
      chk("stray_req_addr", imem_req_addr, 32'h0);
      chk("stray_req_ins", 32'(ins_valid), 32'd0);
      imem_req_ready = 1'b1;
      fetch_one(32'h0, 32'h0000_0066);
      chk("post_rst_addr", imem_req_addr, 32'h4);

      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_pc_fetch_sequencer

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controller that sequences the program counter through instruction fetch.
- Issues one fetch at a time to instruction memory over a valid/ready request and valid-only response interface.
- Buffers the returned word and presents it to decode with a valid/ready handshake.
- Applies redirects (taken branch, jal, jalr targets computed by the PC datapath), discarding any stale in-flight fetch.

Parameters:
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  fetch address (current pc)
- imem_rsp_valid  in  1  response word valid (one per accepted request, latency ≥1)
- imem_rsp_data  in  XLEN  instruction word
- ins_valid  out  1  buffered instruction valid to decode
- ins_ready  in  1  decode consumes instruction
- ins_data  out  XLEN  instruction word
- ins_pc  out  XLEN  address of ins_data
- redirect_valid  in  1  redirect request (taken_br | is_jal | is_jalr)
- redirect_target  in  XLEN  new pc
- misaligned  out  1  one-cycle pulse: redirect_target[1:0] != 0

Behaviour:
- Reset (async):
  - pc = RESET_PC; state = IDLE.
  - imem_req_valid = 0, ins_valid = 0, ins_data = 0, ins_pc = 0, misaligned = 0.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: unconditional -> REQ next cycle (one dead cycle after reset release).
- REQ:
  - imem_req_valid = 1, imem_req_addr = pc.
  - valid & ready -> WAIT.
  - Redirect without accept: pc <= target; stay REQ. The address may change while not accepted.
  - Redirect coincident with accept: pc <= target -> DRAIN (the accepted fetch is stale).
- WAIT:
  - imem_req_valid = 0.
  - rsp_valid: ins_data <= rsp_data, ins_pc <= pc, ins_valid <= 1 -> HOLD.
  - Redirect, no rsp: pc <= target -> DRAIN.
  - Redirect with rsp in the same cycle: response discarded, pc <= target -> REQ.
- HOLD:
  - ins_valid = 1; outputs held stable until the handshake.
  - ins_valid & ins_ready: ins_valid <= 0, pc <= pc + 4 -> REQ.
  - Redirect (with or without handshake): ins_valid <= 0, pc <= target -> REQ. A coincident handshake counts as consumed.
- DRAIN:
  - imem_req_valid = 0; waits for the stale response.
  - rsp_valid: discard -> REQ.
  - Further redirect: pc <= latest target; stay DRAIN.
  - Redirect and rsp together: discard, pc <= target -> REQ.
- Latency:
  - Request issued no earlier than the cycle after entering REQ.
  - ins_valid rises the cycle after rsp_valid.
  - Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Arithmetic: pc + 4 is modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
- Misaligned redirect: pc <= {target[XLEN-1:2], 2'b00}; misaligned pulses 1 the following cycle; sequencing otherwise normal.
- imem_rsp_valid outside WAIT/DRAIN: ignored (protocol error, no state change).
- At most one outstanding fetch at any time.
- Reset mid-operation: immediate return to reset values; any in-flight response after reset release is ignored until the first REQ accept.

Decomposition:
- Shared package fetch_pkg:
  - state encoding constants (IDLE=0, REQ=1, WAIT=2, HOLD=3, DRAIN=4)
  - INSN_BYTES = 4
  - RESET_PC default
- One sub-module is natural: fetch_buffer, a one-entry instruction/pc register with valid/ready output handshake.
- The FSM and pc register stay in pc_fetch_sequencer.

Test Plan:
- Reset release, imem_req_ready = 1, rsp 1 cycle after accept with 32'h0000_0013, ins_ready = 1 -> imem_req_addr 0 then 4; ins_pc 0, ins_data 32'h13; one instruction per 3 cycles.
- ins_ready held 0 for 5 cycles in HOLD -> ins_valid/ins_data/ins_pc stable; no new request; pc advances to +4 only on handshake.
- Redirect to 32'h100 in WAIT, rsp 2 cycles later -> DRAIN, stale word never on ins_*; next request addr 32'h100.
- Redirect to 32'h40 in HOLD with ins_ready = 1 the same cycle -> ins_valid drops next cycle; next request addr 32'h40, not pc+4.
- pc = 32'hFFFF_FFFC, handshake -> next request addr 32'h0; redirect_target 32'h203 -> request addr 32'h200, misaligned pulses once.
- Reset asserted while in DRAIN -> all outputs 0 asynchronously; after release the first request addr is RESET_PC; a stray rsp_valid during IDLE is ignored.
